bytecode_fetch: RTL and testbench
=================================

Name: bytecode_fetch

Overview:
Bytecode prefetch stage sitting directly upstream of the byte-read memory; feeds the bytecode decoder.
- Walks a program counter.
- Issues one byte read at a time over the memory start/ready handshake.
- Buffers returned bytes, each tagged with its PC, in a small FIFO.
- Supports decoder redirects (branch, invoke, return) that flush the buffer and drop any in-flight read.

Parameters:
ADDRESS_WIDTH, 8, width of PC and memory address
FIFO_DEPTH, 4, byte buffer entries; power of two, >=2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
redirect  in  1  one-cycle pulse: flush buffer, restart fetch at redirect_pc
redirect_pc  in  ADDRESS_WIDTH  new fetch PC
mem_address  out  ADDRESS_WIDTH  read address to memory
mem_start  out  1  read request, high for exactly one cycle per read
mem_ready  in  1  memory idle / read data valid
mem_data  in  8  memory read data
out_valid  out  1  buffer head valid
out_data  out  8  head bytecode byte
out_pc  out  ADDRESS_WIDTH  PC of head byte
out_ready  in  1  decoder consumes head when out_valid & out_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered byte count

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_PC; state = IDLE; FIFO empty.
  - out_valid = 0, out_data = 0, out_pc = 0, fifo_count = 0, mem_start = 0.
  - mem_address = RESET_PC.
  - Memory shares the reset source, so no stale response survives reset.
- mem_address = fetch_pc (combinational from register).
- FSM states: IDLE, WAIT, DISCARD.
- IDLE:
  - mem_start = ~redirect & mem_ready & (fifo_count < FIFO_DEPTH), combinational.
  - On start: req_pc <= fetch_pc; fetch_pc <= fetch_pc+1, modulo 2^ADDRESS_WIDTH (FF->00); go WAIT.
  - The slot for the in-flight byte is reserved by the count check; a push can never hit a full FIFO.
- WAIT:
  - Memory drops ready the cycle after start.
  - Capture on first cycle with mem_ready=1: push {req_pc, mem_data}; go IDLE.
  - Latency is variable (1-4+ cycles); the block must not assume a fixed value.
- DISCARD:
  - Wait for mem_ready=1, drop mem_data, go IDLE.
- Redirect (highest priority, any state):
  - fetch_pc <= redirect_pc; FIFO flushed (count 0).
  - Any pop in the same cycle is ignored.
  - No mem_start in that cycle.
  - Per-state transition:
    - IDLE: stay IDLE.
    - WAIT with mem_ready=0: go DISCARD.
    - WAIT with mem_ready=1: response dropped, go IDLE.
    - DISCARD: stay DISCARD, updating fetch_pc only.
- FIFO:
  - out_valid = (count != 0).
  - out_data / out_pc show the head entry; values are undefined-but-stable when empty.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: no effect.
  - Head byte is visible the cycle after its push; no combinational bypass from mem_data.
- Throughput: at most one byte per 2 cycles.
  - mem_start is never asserted on a cycle when mem_ready=0.
  - mem_start is never asserted twice without an intervening capture or discard.

Decomposition:
- Shared package (fetch_pkg):
  - FSM state encoding: IDLE, WAIT, DISCARD.
  - Entry width constant (ADDRESS_WIDTH+8).
  - RESET_PC default.
- Sub-module fetch_fifo: synchronous FIFO, parameterised width/depth.
  - Ports: push, pop, flush, count, head; async active-high reset.
- FSM and PC logic stay in bytecode_fetch.

Test Plan:
Memory model: bytes 0x59, 0x5C, 0x57 at addresses 0-2, zero elsewhere; latency grows with address[1:0].
- Reset, out_ready=1 → decoder sees (pc,data) (00,59), (01,5C), (02,57), (03,00) in order; mem_start is always one-cycle pulses with mem_ready=1.
- out_ready=0 from reset → fifo_count reaches 4, mem_start stays 0, mem_address=04; then one pop → exactly one new read at 04.
- Redirect to 01 while in WAIT for address 03 (mem_ready=0) → FSM goes DISCARD, address 03 data never appears, first output (01,5C), fifo_count was 0 after redirect.
- Redirect to FE → outputs (FE,00), (FF,00), (00,59), (01,5C): PC wraps.
- Redirect asserted with out_valid & out_ready and mem_ready capture in the same cycle → FIFO empty next cycle, captured byte dropped, next output tagged redirect_pc.
- Reset asserted mid-WAIT → outputs immediately at reset values; fetch restarts at RESET_PC with (00,59).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the bytecode prefetch stage.
//   - fetch_state_t : fetch FSM encoding (IDLE / WAIT / DISCARD)
//   - DATA_W        : bytecode width
//   - entry_width() : FIFO entry width for a given address width ({pc, byte})
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int DATA_W                = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_RESET_PC      = 0;
  localparam int DEFAULT_ENTRY_W       = DEFAULT_ADDRESS_WIDTH + DATA_W;

  function automatic int entry_width(input int address_width);
    return address_width + DATA_W;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, byte} entries.
// Ports:
//   clk, reset      : clock, async active-high reset (storage cleared so the
//                     head reads zero out of reset)
//   push/push_data  : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the FIFO; wins over push and pop
//   count           : number of valid entries
//   head            : oldest entry; stale-but-stable when empty
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop  & (count_q != '0);
  assign do_push = push & (count_q != FULL_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = store[rd_ptr];

endmodule

// File: rtl/bytecode_fetch.sv
// Bytecode prefetch stage between the byte-read memory and the decoder.
// Walks a PC, issues one read at a time over mem_start/mem_ready, and buffers
// returned bytes tagged with their PC. A redirect flushes the buffer, reloads
// the PC and drops any read still in flight.
// Ports:
//   clk, reset                : clock, async active-high reset
//   redirect, redirect_pc     : one-cycle restart request and its target PC
//   mem_address, mem_start    : read address (= fetch PC) and one-cycle request
//   mem_ready, mem_data       : memory idle / read data valid, read byte
//   out_valid/out_data/out_pc : buffer head towards the decoder
//   out_ready                 : decoder consumes the head
//   fifo_count                : buffered byte count
module bytecode_fetch
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int RESET_PC      = DEFAULT_RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect,
  input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
  output logic [ADDRESS_WIDTH-1:0]      mem_address,
  output logic                          mem_start,
  input  logic                          mem_ready,
  input  logic [7:0]                    mem_data,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  output logic [ADDRESS_WIDTH-1:0]      out_pc,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = entry_width(ADDRESS_WIDTH);
  localparam logic [CW-1:0]            DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] RESET_ADDR = ADDRESS_WIDTH'(RESET_PC);

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, req_pc;
  logic                     start, push, pop;
  logic [EW-1:0]            head;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state. A redirect in WAIT with mem_ready=1 simply drops the
  // response; with mem_ready=0 the read is still owed, so it is swallowed in
  // DISCARD. A redirect in DISCARD keeps waiting there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT: begin
        if (mem_ready)     state_d = IDLE;
        else if (redirect) state_d = DISCARD;
      end
      DISCARD: if (mem_ready && !redirect) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs / datapath strobes. The count check reserves a slot for the
  // in-flight byte, so a capture never meets a full FIFO.
  always_comb begin
    start = (state_q == IDLE) & ~redirect & mem_ready & (fifo_count < DEPTH_C) & ~reset;
    push  = (state_q == WAIT) & mem_ready & ~redirect;
    pop   = out_ready & ~redirect;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_ADDR;
      req_pc   <= RESET_ADDR;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
    end else if (start) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ADDRESS_WIDTH'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_pc, mem_data}),
    .pop       (pop),
    .flush     (redirect),
    .count     (fifo_count),
    .head      (head)
  );

  assign mem_address = fetch_pc;
  assign mem_start   = start;
  assign out_valid   = (fifo_count != '0);
  assign out_pc      = head[EW-1:8];
  assign out_data    = head[7:0];

endmodule

// File: tb/tb_bytecode_fetch.sv
module tb_bytecode_fetch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic [7:0] mem_address;
  logic       mem_start;
  logic       mem_ready = 1'b1;
  logic [7:0] mem_data = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_pc;
  logic       out_ready = 1'b0;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  bytecode_fetch #(.ADDRESS_WIDTH(8), .FIFO_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_address (mem_address),
    .mem_start   (mem_start),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count)
  );

  typedef struct packed {logic [7:0] pc; logic [7:0] data;} ent_t;

  int          n_tests = 0, n_fail = 0;
  ent_t        q[$];
  logic [15:0] pops[$];
  logic [7:0]  model_fetch, req_addr, last_start;
  bit          pending, cancelled;
  int          start_cnt = 0;
  // memory model state
  bit          mem_busy, start_seen;
  int          rem;
  logic [7:0]  mem_req, start_addr;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h59;
      8'h01:   return 8'h5C;
      8'h02:   return 8'h57;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: ready drops after a start for addr[1:0]+1 cycles, then returns
  // the byte with ready=1. Idle data is junk.
  task automatic drive_mem();
    if (start_seen) begin
      mem_busy = 1; rem = int'(start_addr[1:0]) + 1; mem_req = start_addr; start_seen = 0;
    end
    if (mem_busy && rem > 0) begin
      mem_ready = 0; rem--; mem_data = 8'($urandom);
    end else if (mem_busy) begin
      mem_ready = 1; mem_data = rom(mem_req); mem_busy = 0;
    end else begin
      mem_ready = 1; mem_data = 8'($urandom);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
    drive_mem();
    redirect = 0;
    out_ready = 0;
  endtask

  // Sample away from the edge, check against the scoreboard, then advance it.
  task automatic end_cycle();
    bit exp_start;
    @(negedge clk);
    exp_start = !pending && !redirect && mem_ready && (q.size() < DEPTH);
    chk("mem_start", mem_start, exp_start);
    chk("mem_address", mem_address, model_fetch);
    chk("fifo_count", fifo_count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_data", out_data, q[0].data);
    end
    if (mem_start) begin
      start_seen = 1; start_addr = mem_address; start_cnt++; last_start = mem_address;
    end
    if (redirect) begin
      q.delete();
      model_fetch = redirect_pc;
      if (pending) begin
        if (mem_ready && !cancelled) pending = 0;
        else cancelled = 1;
      end
    end else begin
      if (out_ready && out_valid) pops.push_back({out_pc, out_data});
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (pending && mem_ready) begin
        if (!cancelled) q.push_back(ent_t'{pc: req_addr, data: mem_data});
        pending = 0; cancelled = 0;
      end
      if (mem_start) begin
        pending = 1; cancelled = 0; req_addr = mem_address;
        model_fetch = model_fetch + 8'd1;
      end
    end
  endtask

  task automatic do_reset(input bit ordy);
    reset = 1;
    #1;
    q.delete(); pops.delete();
    model_fetch = 8'h00; pending = 0; cancelled = 0;
    mem_busy = 0; start_seen = 0; mem_ready = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_mem_address", mem_address, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    drive_mem();
    redirect = 0;
    out_ready = ordy;
    end_cycle();
  endtask

  task automatic run_cycles(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      out_ready = ($urandom_range(99) < pct);
      end_cycle();
    end
  endtask

  task automatic chk_pop(input string tag, input int idx, input logic [15:0] exp);
    if (idx < pops.size()) chk(tag, pops[idx], exp);
    else chk(tag, pops.size(), idx + 1);
  endtask

  initial begin
    bit found;
    int s;

    // 1: streaming from reset
    do_reset(1);
    run_cycles(40, 100);
    chk_pop("p1_pop0", 0, 16'h0059);
    chk_pop("p1_pop1", 1, 16'h015C);
    chk_pop("p1_pop2", 2, 16'h0257);
    chk_pop("p1_pop3", 3, 16'h0300);

    // 2: decoder stalled -> buffer fills, fetch stops, one pop frees one read
    do_reset(0);
    run_cycles(40, 0);
    chk("p2_full_count", fifo_count, 4);
    chk("p2_full_addr", mem_address, 8'h04);
    chk("p2_full_nostart", mem_start, 0);
    begin_cycle(); out_ready = 1; end_cycle();
    s = start_cnt;
    run_cycles(20, 0);
    chk("p2_one_read", start_cnt - s, 1);
    chk("p2_read_addr", last_start, 8'h04);

    // 3: redirect to 01 while waiting on address 03
    do_reset(1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      begin_cycle(); out_ready = 1;
      if (pending && req_addr == 8'h03 && !mem_ready) begin
        redirect = 1; redirect_pc = 8'h01; found = 1;
      end
      end_cycle();
    end
    chk("p3_found", found, 1);
    pops.delete();
    begin_cycle(); out_ready = 1; end_cycle();
    chk("p3_flushed", fifo_count, 0);
    run_cycles(40, 100);
    chk_pop("p3_pop0", 0, 16'h015C);
    chk_pop("p3_pop1", 1, 16'h0257);
    chk_pop("p3_pop2", 2, 16'h0300);

    // 4: PC wrap
    do_reset(1);
    begin_cycle(); out_ready = 1; redirect = 1; redirect_pc = 8'hFE; end_cycle();
    pops.delete();
    run_cycles(60, 100);
    chk_pop("p4_pop0", 0, 16'hFE00);
    chk_pop("p4_pop1", 1, 16'hFF00);
    chk_pop("p4_pop2", 2, 16'h0059);
    chk_pop("p4_pop3", 3, 16'h015C);

    // 5: redirect coinciding with a pop and a capture
    do_reset(0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      begin_cycle();
      if (pending && !cancelled && mem_ready && q.size() != 0) begin
        redirect = 1; redirect_pc = 8'h10; out_ready = 1; found = 1;
      end
      end_cycle();
    end
    chk("p5_found", found, 1);
    pops.delete();
    begin_cycle(); end_cycle();
    chk("p5_count", fifo_count, 0);
    chk("p5_valid", out_valid, 0);
    run_cycles(30, 100);
    chk_pop("p5_pop0", 0, 16'h1000);
    chk_pop("p5_pop1", 1, 16'h1100);

    // 6: reset in the middle of a read with bytes buffered
    do_reset(0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      begin_cycle(); end_cycle();
      if (pending && q.size() >= 2) found = 1;
    end
    chk("p6_found", found, 1);
    begin_cycle();
    #2;
    do_reset(1);
    run_cycles(30, 100);
    chk_pop("p6_pop0", 0, 16'h0059);
    chk_pop("p6_pop1", 1, 16'h015C);

    // 7: random decoder stalls and redirects
    for (int i = 0; i < 2000; i++) begin
      begin_cycle();
      out_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 3) begin
        redirect = 1;
        case ($urandom_range(2))
          0:       redirect_pc = 8'hFE;
          1:       redirect_pc = 8'($urandom_range(3));
          default: redirect_pc = 8'($urandom);
        endcase
      end
      end_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
